// File: rtl/countdown_timer.sv
// Two-digit BCD countdown timer with sticky expiry flag and direct seven-segment drive.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload the preset on expiry and pulse done instead.
module countdown_timer #(
    parameter int unsigned TICK_DIV   = 50000000,
    parameter int unsigned PRESCALE_W = 26
) (
    input  logic       clk_50mhz,
    input  logic       reset_n,
    input  logic       load,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] load_value,
    output logic [6:0] seg_tens,
    output logic [6:0] seg_ones,
    output logic       running,
    output logic       done
);

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StRunning = 2'b01,
        StExpired = 2'b10
    } state_e;

    localparam logic [PRESCALE_W-1:0] TickMax = PRESCALE_W'(TICK_DIV - 1);

    state_e                state_q, state_d;
    logic [3:0]            tens_q, tens_d;
    logic [3:0]            ones_q, ones_d;
    logic [7:0]            preset_q, preset_d;
    logic [PRESCALE_W-1:0] prescaler_q, prescaler_d;
    logic                  tick;
    logic                  expire;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic                  done_q, done_d;
`endif

    function automatic logic [3:0] clamp_bcd(input logic [3:0] n);
        return (n > 4'd9) ? 4'd9 : n;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        tens_d      = tens_q;
        ones_d      = ones_q;
        preset_d    = preset_q;
        prescaler_d = prescaler_q;
        tick        = 1'b0;
        expire      = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        done_d      = 1'b0;
`endif

        // The prescaler also advances on a stop cycle, so the tick on that edge still lands.
        if (state_q == StRunning) begin
            if (prescaler_q == TickMax) begin
                prescaler_d = '0;
                tick        = 1'b1;
            end else begin
                prescaler_d = prescaler_q + 1'b1;
            end
        end

        if (tick) begin
            expire = ({tens_q, ones_q} == 8'h01);
            if (ones_q != 4'd0) begin
                ones_d = ones_q - 4'd1;
            end else begin
                ones_d = 4'd9;
                tens_d = tens_q - 4'd1;
            end
        end

        case (state_q)
            StIdle: begin
                if (start && !stop && ({tens_q, ones_q} != 8'h00)) begin
                    state_d = StRunning;
                end
            end
            StRunning: begin
                if (expire) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    tens_d = preset_q[7:4];
                    ones_d = preset_q[3:0];
                    done_d = 1'b1;
                    if (stop) begin
                        state_d = StIdle;
                    end
`else
                    state_d = StExpired;
`endif
                end else if (stop) begin
                    state_d = StIdle;
                end
            end
            StExpired: state_d = StExpired;
            default:   state_d = StIdle;
        endcase

        if (load) begin
            tens_d      = clamp_bcd(load_value[7:4]);
            ones_d      = clamp_bcd(load_value[3:0]);
            preset_d    = {clamp_bcd(load_value[7:4]), clamp_bcd(load_value[3:0])};
            prescaler_d = '0;
            state_d     = StIdle;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            done_d      = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            tens_q      <= 4'd0;
            ones_q      <= 4'd0;
            preset_q    <= 8'h00;
            prescaler_q <= '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            done_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            tens_q      <= tens_d;
            ones_q      <= ones_d;
            preset_q    <= preset_d;
            prescaler_q <= prescaler_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            done_q      <= done_d;
`endif
        end
    end

    assign running  = (state_q == StRunning);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    assign done     = done_q;
`else
    assign done     = (state_q == StExpired);
`endif
    assign seg_tens = seg_decode(tens_q);
    assign seg_ones = seg_decode(ones_q);

endmodule
